// File: rtl/cdr_fifo_pkg.sv
// Shared definitions for the CDR symbol FIFO.
//   - default configuration values used by the top and its sub-module
//   - symbol and pointer types for the default configuration
//   - threshold helpers for the almost-empty and almost-full flags
package cdr_fifo_pkg;

    localparam int unsigned SYM_WIDTH_DEF      = 4;
    localparam int unsigned FIFO_DEPTH_BIT_DEF = 7;
    localparam int unsigned DEPTH              = 2 ** FIFO_DEPTH_BIT_DEF;

    typedef logic [SYM_WIDTH_DEF-1:0]   sym_t;
    typedef logic [FIFO_DEPTH_BIT_DEF:0] ptr_t;

    function automatic logic is_almost_empty(input int unsigned level,
                                             input int unsigned th);
        return level <= th;
    endfunction

    // Written as level + th >= depth so a threshold larger than the depth
    // cannot wrap around.
    function automatic logic is_almost_full(input int unsigned level,
                                            input int unsigned depth,
                                            input int unsigned th);
        return (level + th) >= depth;
    endfunction

endpackage

// File: rtl/cdr_bit_packer.sv
// Serial-to-symbol packer for the CDR output path.
// Collects recovered bits into SYM_WIDTH-bit symbols and emits a one-cycle
// push pulse with the registered symbol when a symbol completes or when a
// flush arrives with a partial symbol pending.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bit_valid   recovered-bit strobe
//   rx_bit      recovered bit, sampled with bit_valid
//   flush       emit the pending partial symbol, zero-padded
//   push        one-cycle pulse, sym holds a new symbol
//   sym         packed symbol
module cdr_bit_packer
    import cdr_fifo_pkg::*;
#(
    parameter int unsigned SYM_WIDTH = SYM_WIDTH_DEF,
    parameter int unsigned MSB_FIRST = 1
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 bit_valid,
    input  logic                 rx_bit,
    input  logic                 flush,
    output logic                 push,
    output logic [SYM_WIDTH-1:0] sym
);

    localparam int unsigned CW = $clog2(SYM_WIDTH);
    localparam logic [CW-1:0] LAST    = CW'(SYM_WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [CW-1:0]        count;
    logic [CW-1:0]        pos;
    logic [SYM_WIDTH-1:0] shreg;
    logic [SYM_WIDTH-1:0] shreg_ins;

    // Shift register with the incoming bit already placed at its slot.
    always_comb begin
        pos            = (MSB_FIRST != 0) ? (LAST - count) : count;
        shreg_ins      = shreg;
        shreg_ins[pos] = rx_bit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            shreg <= '0;
            push  <= 1'b0;
            sym   <= '0;
        end else begin
            push <= 1'b0;
            if (bit_valid) begin
                // The bit is taken first; a flush alongside a completing bit
                // collapses into the normal push.
                if (count == LAST || flush) begin
                    sym   <= shreg_ins;
                    push  <= 1'b1;
                    shreg <= '0;
                    count <= '0;
                end else begin
                    shreg <= shreg_ins;
                    count <= count + CNT_ONE;
                end
            end else if (flush && count != '0) begin
                // Unfilled slots are already zero because shreg is cleared
                // after every push.
                sym   <= shreg;
                push  <= 1'b1;
                shreg <= '0;
                count <= '0;
            end
        end
    end

endmodule

// File: rtl/cdr_symbol_fifo.sv
// CDR symbol FIFO: packs recovered bits into symbols, buffers them in a
// 2**FIFO_DEPTH_BIT entry FIFO and serves a CPU-side reader.
// Ports:
//   i_clk, i_rst_n               clock, asynchronous active-low reset
//   i_bit_valid, i_bit           recovered bit stream from the CDR
//   i_flush                      emit pending partial symbol, zero-padded
//   i_rd_en                      read request
//   i_clear                      clear sticky errors, done and frame counter
//   o_data, o_data_valid         registered read data and its strobe
//   o_level                      number of stored symbols
//   o_full, o_empty              level == depth / level == 0
//   o_almost_full, o_almost_empty threshold flags
//   o_wr_err, o_rd_err           sticky overflow / underflow
//   o_done                       sticky, FRAME_SYMS symbols accepted
module cdr_symbol_fifo
    import cdr_fifo_pkg::*;
#(
    parameter int unsigned SYM_WIDTH       = SYM_WIDTH_DEF,
    parameter int unsigned FIFO_DEPTH_BIT  = FIFO_DEPTH_BIT_DEF,
    parameter int unsigned ALMOST_EMPTY_TH = 4,
    parameter int unsigned ALMOST_FULL_TH  = 4,
    parameter int unsigned FRAME_SYMS      = 64,
    parameter int unsigned MSB_FIRST       = 1
)(
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_bit_valid,
    input  logic                    i_bit,
    input  logic                    i_flush,
    input  logic                    i_rd_en,
    input  logic                    i_clear,
    output logic [SYM_WIDTH-1:0]    o_data,
    output logic                    o_data_valid,
    output logic [FIFO_DEPTH_BIT:0] o_level,
    output logic                    o_full,
    output logic                    o_empty,
    output logic                    o_almost_full,
    output logic                    o_almost_empty,
    output logic                    o_wr_err,
    output logic                    o_rd_err,
    output logic                    o_done
);

    localparam int unsigned AW          = FIFO_DEPTH_BIT;
    localparam int unsigned PW          = FIFO_DEPTH_BIT + 1;
    localparam int unsigned NUM_ENTRIES = 2 ** FIFO_DEPTH_BIT;
    localparam int unsigned FCW         = (FRAME_SYMS > 0) ? $clog2(FRAME_SYMS + 1) : 1;

    localparam logic [PW-1:0]  PTR_ONE  = PW'(1);
    localparam logic [FCW-1:0] FC_ONE   = FCW'(1);
    localparam logic [FCW-1:0] FRAME_TC = FCW'(FRAME_SYMS);

    logic                 push;
    logic [SYM_WIDTH-1:0] push_sym;

    logic [SYM_WIDTH-1:0] mem [NUM_ENTRIES];

    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [PW-1:0]  wr_ptr_next, rd_ptr_next;
    logic [PW-1:0]  level_next;
    logic           full_next, empty_next;
    logic           rd_ok, wr_ok;
    logic           wr_err_evt, rd_err_evt;
    logic [FCW-1:0] frame_cnt, frame_cnt_base, frame_cnt_next;
    logic           done_next;

    cdr_bit_packer #(
        .SYM_WIDTH (SYM_WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_packer (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .bit_valid (i_bit_valid),
        .rx_bit    (i_bit),
        .flush     (i_flush),
        .push      (push),
        .sym       (push_sym)
    );

    // A read frees a slot in the same edge, so a full FIFO still accepts a
    // write that coincides with a read.
    assign rd_ok      = i_rd_en & ~o_empty;
    assign wr_ok      = push & (~o_full | rd_ok);
    assign wr_err_evt = push & o_full & ~rd_ok;
    assign rd_err_evt = i_rd_en & o_empty;

    always_comb begin
        wr_ptr_next = wr_ok ? (wr_ptr + PTR_ONE) : wr_ptr;
        rd_ptr_next = rd_ok ? (rd_ptr + PTR_ONE) : rd_ptr;
        case ({wr_ok, rd_ok})
            2'b10:   level_next = o_level + PTR_ONE;
            2'b01:   level_next = o_level - PTR_ONE;
            default: level_next = o_level;
        endcase
        full_next  = (wr_ptr_next[AW] != rd_ptr_next[AW]) &&
                     (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);
        empty_next = (wr_ptr_next == rd_ptr_next);
    end

    // Saturating frame counter; a clear restarts it but a write in the same
    // cycle still counts.
    always_comb begin
        frame_cnt_base = i_clear ? '0 : frame_cnt;
        frame_cnt_next = frame_cnt_base;
        if (wr_ok && frame_cnt_base != FRAME_TC)
            frame_cnt_next = frame_cnt_base + FC_ONE;
        done_next = (FRAME_SYMS != 0) && (frame_cnt_next == FRAME_TC);
    end

    always_ff @(posedge i_clk) begin
        if (wr_ok)
            mem[wr_ptr[AW-1:0]] <= push_sym;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            o_level        <= '0;
            o_full         <= 1'b0;
            o_empty        <= 1'b1;
            o_almost_full  <= 1'b0;
            o_almost_empty <= 1'b1;
            o_data         <= '0;
            o_data_valid   <= 1'b0;
            o_wr_err       <= 1'b0;
            o_rd_err       <= 1'b0;
            o_done         <= 1'b0;
            frame_cnt      <= '0;
        end else begin
            wr_ptr         <= wr_ptr_next;
            rd_ptr         <= rd_ptr_next;
            o_level        <= level_next;
            o_full         <= full_next;
            o_empty        <= empty_next;
            o_almost_full  <= is_almost_full(32'(level_next), NUM_ENTRIES, ALMOST_FULL_TH);
            o_almost_empty <= is_almost_empty(32'(level_next), ALMOST_EMPTY_TH);
            o_data_valid   <= rd_ok;
            // When full, read and write share an address; the read sees the
            // old head because the memory updates with non-blocking timing.
            if (rd_ok)
                o_data <= mem[rd_ptr[AW-1:0]];
            // An error in the clearing cycle keeps its flag set.
            o_wr_err  <= wr_err_evt | (o_wr_err & ~i_clear);
            o_rd_err  <= rd_err_evt | (o_rd_err & ~i_clear);
            frame_cnt <= frame_cnt_next;
            o_done    <= done_next;
        end
    end

endmodule

// File: tb/tb_cdr_symbol_fifo.sv
module tb_cdr_symbol_fifo;
    import cdr_fifo_pkg::*;

    localparam int DEPTH_TB = 128;
    localparam int NV       = 11;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b1;
    logic       i_bit_valid = 1'b0;
    logic       i_bit = 1'b0;
    logic       i_flush = 1'b0;
    logic       i_rd_en = 1'b0;
    logic       i_clear = 1'b0;
    logic [3:0] o_data;
    logic       o_data_valid;
    logic [7:0] o_level;
    logic       o_full, o_empty, o_almost_full, o_almost_empty;
    logic       o_wr_err, o_rd_err, o_done;

    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0] exp_q[$];
    logic [3:0] last_exp = 4'h0;

    typedef struct {
        logic [3:0] seq;   // bits sent from seq[3] downwards
        int         n;     // number of bits sent
        int         mode;  // 0 plain, 1 separate flush after bits, 2 flush with last bit
        logic [3:0] exp;
    } vec_t;
    vec_t vecs[NV];

    cdr_symbol_fifo #(
        .SYM_WIDTH(4), .FIFO_DEPTH_BIT(7), .ALMOST_EMPTY_TH(4),
        .ALMOST_FULL_TH(4), .FRAME_SYMS(64), .MSB_FIRST(1)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_bit_valid(i_bit_valid),
        .i_bit(i_bit), .i_flush(i_flush), .i_rd_en(i_rd_en), .i_clear(i_clear),
        .o_data(o_data), .o_data_valid(o_data_valid), .o_level(o_level),
        .o_full(o_full), .o_empty(o_empty), .o_almost_full(o_almost_full),
        .o_almost_empty(o_almost_empty), .o_wr_err(o_wr_err),
        .o_rd_err(o_rd_err), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every read strobe must match the oldest expected symbol.
    always @(negedge i_clk) begin
        if (i_rst_n === 1'b1 && o_data_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL read_unexpected: got %0h, expected no read", o_data);
            end else begin
                last_exp = exp_q.pop_front();
                check("read_data", 32'(o_data), 32'(last_exp));
            end
        end
    end

    // Flags must always agree with the reported level.
    always @(negedge i_clk) begin
        if (i_rst_n === 1'b1) begin
            check("flag_full",   32'(o_full),         32'(o_level == 8'(DEPTH_TB)));
            check("flag_empty",  32'(o_empty),        32'(o_level == 8'd0));
            check("flag_afull",  32'(o_almost_full),  32'(o_level >= 8'd124));
            check("flag_aempty", 32'(o_almost_empty), 32'(o_level <= 8'd4));
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive_idle();
        i_bit_valid = 1'b0; i_bit = 1'b0; i_flush = 1'b0;
        i_rd_en = 1'b0; i_clear = 1'b0;
    endtask

    task automatic idle(input int n);
        drive_idle();
        repeat (n) tick();
    endtask

    task automatic send_bit(input logic b, input logic fl);
        i_bit_valid = 1'b1; i_bit = b; i_flush = fl;
        tick();
        drive_idle();
    endtask

    task automatic send_sym(input logic [3:0] s, input bit will_write);
        if (will_write) exp_q.push_back(s);
        for (int i = 3; i >= 0; i--) send_bit(s[i], 1'b0);
    endtask

    task automatic read_n(input int n);
        i_rd_en = 1'b1;
        repeat (n) tick();
        i_rd_en = 1'b0;
    endtask

    task automatic do_reset();
        drive_idle();
        i_rst_n = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge i_clk);
        #3;
        i_rst_n = 1'b1;
        tick();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_level"},  32'(o_level), 0);
        check({tag, "_data"},   32'(o_data), 0);
        check({tag, "_dvalid"}, 32'(o_data_valid), 0);
        check({tag, "_full"},   32'(o_full), 0);
        check({tag, "_empty"},  32'(o_empty), 1);
        check({tag, "_afull"},  32'(o_almost_full), 0);
        check({tag, "_aempty"}, 32'(o_almost_empty), 1);
        check({tag, "_wrerr"},  32'(o_wr_err), 0);
        check({tag, "_rderr"},  32'(o_rd_err), 0);
        check({tag, "_done"},   32'(o_done), 0);
    endtask

    initial begin
        logic [3:0] s;

        vecs[0]  = '{4'b1011, 4, 0, 4'hB};
        vecs[1]  = '{4'b0001, 4, 0, 4'h1};
        vecs[2]  = '{4'b1000, 4, 0, 4'h8};
        vecs[3]  = '{4'b1100, 2, 1, 4'hC};
        vecs[4]  = '{4'b1000, 1, 1, 4'h8};
        vecs[5]  = '{4'b1010, 3, 1, 4'hA};
        vecs[6]  = '{4'b0000, 1, 1, 4'h0};
        vecs[7]  = '{4'b1011, 4, 2, 4'hB};
        vecs[8]  = '{4'b0100, 2, 2, 4'h4};
        vecs[9]  = '{4'b1110, 3, 2, 4'hE};
        vecs[10] = '{4'b0110, 4, 0, 4'h6};

        #2;
        do_reset();
        check_reset_vals("rst");

        // Underflow right after reset, then clear (with and without collision).
        i_rd_en = 1'b1; tick(); drive_idle();
        check("uf_rderr", 32'(o_rd_err), 1);
        check("uf_dvalid", 32'(o_data_valid), 0);
        check("uf_data", 32'(o_data), 0);
        i_rd_en = 1'b1; i_clear = 1'b1; tick(); drive_idle();
        check("uf_clear_collide", 32'(o_rd_err), 1);
        i_clear = 1'b1; tick(); drive_idle();
        check("uf_cleared", 32'(o_rd_err), 0);

        // First symbol latency and read.
        do_reset();
        exp_q.push_back(4'hB);
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
        check("lat_still_empty", 32'(o_empty), 1);
        idle(1);
        check("lat_not_empty", 32'(o_empty), 0);
        check("lat_level", 32'(o_level), 1);
        read_n(1);
        check("rd_dvalid", 32'(o_data_valid), 1);
        check("rd_data", 32'(o_data), 32'h0B);
        idle(1);
        check("rd_dvalid_pulse", 32'(o_data_valid), 0);
        check("rd_empty", 32'(o_empty), 1);

        // Packing and flush table.
        for (int i = 0; i < NV; i++) begin
            for (int k = 0; k < vecs[i].n; k++)
                send_bit(vecs[i].seq[3-k], (vecs[i].mode == 2) && (k == vecs[i].n - 1));
            if (vecs[i].mode == 1) begin
                i_flush = 1'b1; tick(); drive_idle();
            end
            exp_q.push_back(vecs[i].exp);
            idle(2);
            check("vec_level", 32'(o_level), 32'(i + 1));
        end
        i_flush = 1'b1; tick(); idle(2);
        check("flush_noop_level", 32'(o_level), NV);
        read_n(NV);
        idle(2);
        check("vec_drained", 32'(o_empty), 1);
        check("vec_q_empty", 32'(exp_q.size()), 0);
        i_rd_en = 1'b1; tick(); drive_idle();
        check("hold_rderr", 32'(o_rd_err), 1);
        check("hold_data", 32'(o_data), 32'(last_exp));
        check("hold_dvalid", 32'(o_data_valid), 0);

        // Asynchronous reset mid-stream discards FIFO contents and partial bits.
        send_sym(4'h3, 1'b1);
        send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
        #3 i_rst_n = 1'b0;
        #1;
        check_reset_vals("arst");
        exp_q.delete();
        @(posedge i_clk);
        #3 i_rst_n = 1'b1;
        tick();
        send_sym(4'h5, 1'b1);
        idle(2);
        check("arst_level", 32'(o_level), 1);
        read_n(1);
        idle(2);
        check("arst_q_empty", 32'(exp_q.size()), 0);

        // Fill to full, done at 64, overflow.
        do_reset();
        for (int k = 0; k < 63; k++) send_sym(4'($urandom_range(0, 15)), 1'b1);
        idle(2);
        check("fill_level63", 32'(o_level), 63);
        check("done_before", 32'(o_done), 0);
        send_sym(4'($urandom_range(0, 15)), 1'b1);
        idle(2);
        check("done_at64", 32'(o_done), 1);
        for (int k = 0; k < 59; k++) send_sym(4'($urandom_range(0, 15)), 1'b1);
        idle(2);
        check("fill_level123", 32'(o_level), 123);
        check("afull_123", 32'(o_almost_full), 0);
        send_sym(4'($urandom_range(0, 15)), 1'b1);
        idle(2);
        check("fill_level124", 32'(o_level), 124);
        check("afull_124", 32'(o_almost_full), 1);
        for (int k = 0; k < 4; k++) send_sym(4'($urandom_range(0, 15)), 1'b1);
        idle(2);
        check("fill_full", 32'(o_full), 1);
        check("fill_level128", 32'(o_level), 128);
        check("fill_no_wrerr", 32'(o_wr_err), 0);
        send_sym(4'($urandom_range(0, 15)), 1'b0);
        idle(2);
        check("ovf_level", 32'(o_level), 128);
        check("ovf_wrerr", 32'(o_wr_err), 1);

        i_clear = 1'b1; tick(); drive_idle();
        check("clr_wrerr", 32'(o_wr_err), 0);
        check("clr_done", 32'(o_done), 0);
        check("clr_level", 32'(o_level), 128);

        // Full FIFO with a read on every push cycle, across pointer wrap.
        for (int k = 0; k < 300; k++) begin
            s = 4'($urandom_range(0, 15));
            exp_q.push_back(s);
            for (int b = 3; b >= 0; b--) begin
                i_bit_valid = 1'b1;
                i_bit = s[b];
                i_rd_en = (k > 0) && (b == 3);
                tick();
                check("wrap_level", 32'(o_level), 128);
            end
        end
        i_bit_valid = 1'b0; i_bit = 1'b0; i_rd_en = 1'b1;
        tick();
        idle(2);
        check("wrap_level_end", 32'(o_level), 128);
        check("wrap_no_wrerr", 32'(o_wr_err), 0);
        check("wrap_done", 32'(o_done), 1);
        read_n(128);
        idle(2);
        check("drain_empty", 32'(o_empty), 1);
        check("drain_q_empty", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cdr_symbol_fifo.md
Name: cdr_symbol_fifo

Overview:
Parametrised successor to the fixed 1-bit-in/4-bit-out CDR output FIFO. It packs the serial recovered bits from cdr (data + flag) into SYM_WIDTH-bit symbols, buffers them in a 2**FIFO_DEPTH_BIT entry FIFO, and presents them to the CPU-side reader. It adds over the previous generation:
- configurable width, depth and thresholds
- bit order selection
- partial-symbol flush
- sticky, clearable error flags
- frame-complete (done) detection

Parameters:
SYM_WIDTH, 4, bits per packed symbol (>=2)
FIFO_DEPTH_BIT, 7, log2 of FIFO entries (depth 128 by default)
ALMOST_EMPTY_TH, 4, almost_empty asserted when level <= this
ALMOST_FULL_TH, 4, almost_full asserted when level >= depth - this
FRAME_SYMS, 64, accepted-symbol count that raises o_done; 0 disables done
MSB_FIRST, 1, 1: first received bit lands in symbol MSB; 0: in LSB

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_bit_valid  in  1  cdr flag, one-cycle pulse per recovered bit
i_bit  in  1  cdr recovered bit, sampled when i_bit_valid=1
i_flush  in  1  pulse: emit current partial symbol zero-padded
i_rd_en  in  1  read request from CPU side
i_clear  in  1  pulse: clear sticky errors, done and frame counter (not FIFO contents)
o_data  out  SYM_WIDTH  registered read data
o_data_valid  out  1  one-cycle pulse, o_data updated this cycle
o_level  out  FIFO_DEPTH_BIT+1  current number of stored symbols
o_full / o_empty  out  1  level == depth / level == 0
o_almost_full / o_almost_empty  out  1  threshold flags as above
o_wr_err / o_rd_err  out  1  sticky overflow / underflow flags
o_done  out  1  sticky, FRAME_SYMS symbols accepted since reset/clear

Behaviour:
Reset (async assert, sync release):
- pointers, level, packer count, frame counter = 0
- o_empty=1, o_almost_empty=1; all other outputs 0
- A partial symbol held at reset is discarded, including when reset is asserted mid-stream.

Packer:
- Shift register plus bit counter 0..SYM_WIDTH-1.
- Each i_bit_valid stores i_bit at position count (MSB-down if MSB_FIRST, else LSB-up).
- When the bit at count=SYM_WIDTH-1 arrives, the symbol is registered with an internal push pulse at that edge and the counter returns to 0.
- Flush with count>0: push the partial symbol, unfilled positions = 0, count returns to 0. Flush with count=0: no-op.
- i_flush together with i_bit_valid: the bit is taken first.
  - If that bit completes the symbol, only the normal push occurs (no extra empty symbol).
  - Otherwise the flush pushes the padded symbol including that bit.

FIFO write and read:
- Write happens at the edge after the push pulse. Latency from the last bit's edge to o_empty=0 is 2 clocks.
- Write when full (level == depth before the edge) with no read: symbol dropped, o_wr_err set.
- Read: i_rd_en with o_empty=0 gives, at the next edge, o_data = head entry and o_data_valid=1 for one cycle. Read path is first-word-not-fall-through.
- i_rd_en when empty: ignored, o_rd_err set, o_data holds its previous value.

Simultaneous events:
- Write and read while full: both accepted, level unchanged, no error.
- Write and read while empty: write accepted, read flagged as underflow, level becomes 1.

Pointers and flags:
- Pointers are FIFO_DEPTH_BIT+1 bits wide and wrap naturally.
- full = MSBs differ and lower bits equal; empty = pointers equal.
- Level is +1, -1 or 0 per cycle. All flags are registered and consistent with o_level in the same cycle.

Errors and done:
- Sticky until i_clear. An error event in the same cycle as i_clear wins (flag stays set).
- Frame counter increments on each accepted write and saturates at FRAME_SYMS. o_done is asserted at the edge of the FRAME_SYMS-th accepted write.
- i_clear resets the counter and o_done.

Decomposition:
- Package cdr_fifo_pkg holds:
  - typedef sym_t (logic [SYM_WIDTH-1:0]) and ptr_t
  - localparam DEPTH = 2**FIFO_DEPTH_BIT
  - threshold check functions
- Sub-module cdr_bit_packer covers shift register, bit counter, flush and the push pulse.
- FIFO memory, pointers, flags, errors and done stay in the top.

Test Plan:
1. Reset, bits 1,0,1,1 (MSB_FIRST=1) -> two clocks after the last bit o_empty=0, o_level=1. Then i_rd_en -> next cycle o_data=4'hB, o_data_valid=1.
2. Stream 512 bits (128 symbols) without reads -> o_almost_full=1 from level 124, o_full=1 at 128. Next symbol dropped, o_wr_err=1, o_level stays 128.
3. i_rd_en right after reset -> o_rd_err=1, o_data_valid=0, o_data=0. Then i_clear -> o_rd_err=0.
4. Bits 1,1 then i_flush -> symbol 4'hC written. Same flush with i_bit_valid=1 on the 4th bit -> exactly one symbol written.
5. Full FIFO with simultaneous write and read each cycle for 300 symbols -> o_level stays 128, no o_wr_err, read order matches write order across pointer wrap.
6. FRAME_SYMS=64 -> o_done rises at the 64th accepted write. Async reset mid-symbol -> all outputs at reset values, partial bits lost, first post-reset symbol built from new bits only.
